// File: rtl/sound_sequencer.sv
// Timed note/delay sequencer feeding the square-wave sound block.
// Optional low-water IRQ enabled by defining SOUND_SEQ_IRQ_EN.
module sound_sequencer #(
  parameter int DEPTH_LOG2 = 4,
  parameter int TICK_DIV   = 50000,
  parameter int LOW_WATER  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        wr_en,
  input  logic [1:0]  addr,
  input  logic [15:0] data_in,
  output logic [15:0] data_out,
  output logic        snd_wr_en,
  output logic [15:0] snd_data,
  output logic        irq
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [15:0] TICK_RLD = 16'(TICK_DIV - 1);
  localparam logic [DEPTH_LOG2:0] LOW_W = (DEPTH_LOG2 + 1)'(LOW_WATER);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE = DEPTH_LOG2'(1);
  localparam logic [DEPTH_LOG2:0] LVL_ONE = (DEPTH_LOG2 + 1)'(1);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    WAIT
  } state_t;

  state_t state_q, state_d;

  logic [16:0] mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wptr_q, wptr_d;
  logic [DEPTH_LOG2-1:0] rptr_q, rptr_d;
  logic [DEPTH_LOG2:0] level_q, level_d;
  logic ovf_q, ovf_d;
  logic [16:0] cmd_q, cmd_d;
  logic [15:0] rem_q, rem_d;
  logic [15:0] tick_q, tick_d;
  logic snd_wr_en_q, snd_wr_en_d;
  logic [15:0] snd_data_q, snd_data_d;

  logic push_req;
  logic ctrl_wr;
  logic flush;
  logic full;
  logic push;
  logic pop;
  logic busy;

  // Decode CPU writes; fullness is judged before any same-cycle pop.
  always_comb begin
    push_req = wr_en && (addr == 2'd0 || addr == 2'd1);
    ctrl_wr  = wr_en && (addr == 2'd2);
    flush    = ctrl_wr && data_in[0];
    full     = level_q[DEPTH_LOG2];
    push     = push_req && !full && !flush;
    pop      = (state_q == IDLE) && en && (level_q != '0) && !flush;
    busy     = (state_q != IDLE) || (level_q != '0);
  end

  // FIFO pointer, level and overflow bookkeeping.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q;
    ovf_d   = ovf_q;
    if (flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      level_d = '0;
      ovf_d   = 1'b0;
    end else begin
      if (push) wptr_d = wptr_q + PTR_ONE;
      if (pop)  rptr_d = rptr_q + PTR_ONE;
      if (push && !pop) level_d = level_q + LVL_ONE;
      if (pop && !push) level_d = level_q - LVL_ONE;
      if (push_req && full) ovf_d = 1'b1;
    end
  end

  // Playback FSM: fetch, execute a note or delay, then count ticks.
  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    rem_d       = rem_q;
    tick_d      = tick_q;
    snd_wr_en_d = 1'b0;
    snd_data_d  = snd_data_q;
    unique case (state_q)
      IDLE: begin
        if (pop) begin
          cmd_d   = mem_q[rptr_q];
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (!cmd_q[16]) begin
          snd_wr_en_d = 1'b1;
          snd_data_d  = cmd_q[15:0];
          state_d     = IDLE;
        end else if (cmd_q[15:0] == '0) begin
          state_d = IDLE;
        end else begin
          rem_d   = cmd_q[15:0];
          tick_d  = TICK_RLD;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (en) begin
          if (tick_q != '0) begin
            tick_d = tick_q - 16'd1;
          end else if (rem_q == 16'd1) begin
            state_d = IDLE;
          end else begin
            rem_d  = rem_q - 16'd1;
            tick_d = TICK_RLD;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (flush) begin
      state_d     = IDLE;
      snd_wr_en_d = 1'b0;
    end
  end

  // FIFO storage; unread slots never need a reset value.
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= {addr[0], data_in};
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      wptr_q      <= '0;
      rptr_q      <= '0;
      level_q     <= '0;
      ovf_q       <= 1'b0;
      cmd_q       <= '0;
      rem_q       <= '0;
      tick_q      <= '0;
      snd_wr_en_q <= 1'b0;
      snd_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      level_q     <= level_d;
      ovf_q       <= ovf_d;
      cmd_q       <= cmd_d;
      rem_q       <= rem_d;
      tick_q      <= tick_d;
      snd_wr_en_q <= snd_wr_en_d;
      snd_data_q  <= snd_data_d;
    end
  end

`ifdef SOUND_SEQ_IRQ_EN
  logic irq_en_q, irq_en_d;

  // Control bit1 arms the low-water interrupt.
  always_comb begin
    irq_en_d = irq_en_q;
    if (ctrl_wr) irq_en_d = data_in[1];
  end

  // IRQ enable register.
  always_ff @(posedge clk) begin
    if (rst) irq_en_q <= 1'b0;
    else     irq_en_q <= irq_en_d;
  end

  // Level-sensitive low-water interrupt.
  always_comb begin
    irq = irq_en_q && (level_q <= LOW_W);
  end
`else
  logic unused_low_water;

  // Interrupt feature absent: output held low.
  always_comb begin
    unused_low_water = (level_q <= LOW_W);
    irq = 1'b0;
  end
`endif

  // Status word and registered sound-block outputs.
  always_comb begin
    data_out = '0;
    data_out[DEPTH_LOG2:0] = level_q;
    data_out[14] = busy;
    data_out[15] = ovf_q;
    snd_wr_en = snd_wr_en_q;
    snd_data  = snd_data_q;
  end

endmodule

// File: tb/tb_sound_sequencer.sv
// Directed bench for sound_sequencer with TICK_DIV=4.
// Expected IRQ behaviour follows SOUND_SEQ_IRQ_EN.
module tb_sound_sequencer;

  localparam int DL = 4;
  localparam int TD = 4;
  localparam int LW = 4;
`ifdef SOUND_SEQ_IRQ_EN
  localparam logic IRQ_ON = 1'b1;
`else
  localparam logic IRQ_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic en;
  logic wr_en;
  logic [1:0] addr;
  logic [15:0] data_in;
  logic [15:0] data_out;
  logic snd_wr_en;
  logic [15:0] snd_data;
  logic irq;

  int total = 0;
  int bad = 0;
  int n;
  int cnt;
  logic busy_ok;

  always #5 clk = ~clk;

  sound_sequencer #(
    .DEPTH_LOG2(DL),
    .TICK_DIV(TD),
    .LOW_WATER(LW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .wr_en(wr_en),
    .addr(addr),
    .data_in(data_in),
    .data_out(data_out),
    .snd_wr_en(snd_wr_en),
    .snd_data(snd_data),
    .irq(irq)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_wr(input logic [1:0] a, input logic [15:0] d);
    wr_en = 1'b1;
    addr = a;
    data_in = d;
    tick();
    wr_en = 1'b0;
    addr = 2'd0;
    data_in = 16'd0;
  endtask

  task automatic wait_pulse(input int limit, output int cyc);
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (!snd_wr_en && cyc < limit);
    if (!snd_wr_en) cyc = -1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    en = 1'b0;
    wr_en = 1'b0;
    addr = 2'd0;
    data_in = 16'd0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_dout", data_out, 16'h0000);
    chk("rst_wr", snd_wr_en, 1'b0);
    chk("rst_data", snd_data, 16'h0000);
    chk("rst_irq", irq, 1'b0);

    en = 1'b1;
    cpu_wr(2'd0, 16'h4123);
    chk("note_e0", snd_wr_en, 1'b0);
    tick();
    chk("note_e1", snd_wr_en, 1'b0);
    tick();
    chk("note_pulse", snd_wr_en, 1'b1);
    chk("note_data", snd_data, 16'h4123);
    tick();
    chk("note_after", snd_wr_en, 1'b0);
    chk("note_dout", data_out, 16'h0000);

    en = 1'b0;
    cpu_wr(2'd0, 16'h0010);
    cpu_wr(2'd1, 16'd3);
    cpu_wr(2'd0, 16'h0020);
    chk("dly_level", data_out, 16'h4003);
    en = 1'b1;
    wait_pulse(10, n);
    chk("dly_lat", n, 2);
    chk("dly_d1", snd_data, 16'h0010);
    busy_ok = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
      if (!snd_wr_en && !data_out[14]) busy_ok = 1'b0;
    end while (!snd_wr_en && n < 100);
    chk("dly_gap", n, 16);
    chk("dly_d2", snd_data, 16'h0020);
    chk("dly_busy", busy_ok, 1'b1);
    tick();
    chk("dly_end", data_out, 16'h0000);

    en = 1'b0;
    cpu_wr(2'd0, 16'h0030);
    cpu_wr(2'd1, 16'd3);
    cpu_wr(2'd0, 16'h0040);
    en = 1'b1;
    wait_pulse(10, n);
    chk("pau_lat", n, 2);
    repeat (6) tick();
    en = 1'b0;
    repeat (5) tick();
    en = 1'b1;
    wait_pulse(100, n);
    chk("pau_gap", n + 11, 21);
    chk("pau_d2", snd_data, 16'h0040);

    tick();
    en = 1'b0;
    cpu_wr(2'd0, 16'h0001);
    cpu_wr(2'd0, 16'h0002);
    cnt = 0;
    repeat (4) begin
      tick();
      if (snd_wr_en) cnt++;
    end
    chk("idle_nowr", cnt, 0);
    chk("idle_lvl", data_out, 16'h4002);
    cpu_wr(2'd2, 16'h0001);
    chk("idle_flush", data_out, 16'h0000);

    for (int i = 0; i < 16; i++) cpu_wr(2'd0, 16'(i));
    chk("ovf_full", data_out, 16'h4010);
    cpu_wr(2'd0, 16'hFFFF);
    chk("ovf_set", data_out, 16'hC010);
    cpu_wr(2'd2, 16'h0001);
    chk("ovf_flush", data_out, 16'h0000);
    for (int i = 0; i < 16; i++) cpu_wr(2'd0, 16'(i));
    en = 1'b1;
    cpu_wr(2'd0, 16'hEEEE);
    chk("ovf_pop", data_out, 16'hC00F);
    en = 1'b0;
    cpu_wr(2'd2, 16'h0001);
    chk("ovf_fl_wr", snd_wr_en, 1'b0);
    chk("ovf_fl_do", data_out, 16'h0000);

    cpu_wr(2'd0, 16'h1111);
    en = 1'b1;
    cpu_wr(2'd2, 16'h0001);
    chk("fl_pop_do", data_out, 16'h0000);
    cnt = 0;
    repeat (3) begin
      tick();
      if (snd_wr_en) cnt++;
    end
    chk("fl_pop_wr", cnt, 0);

    cpu_wr(2'd0, 16'h2222);
    tick();
    chk("fl_exec", data_out, 16'h4000);
    cpu_wr(2'd2, 16'h0001);
    chk("fl_exec_wr", snd_wr_en, 1'b0);
    chk("fl_exec_do", data_out, 16'h0000);
    cnt = 0;
    repeat (3) begin
      tick();
      if (snd_wr_en) cnt++;
    end
    chk("fl_exec_nw", cnt, 0);

    en = 1'b0;
    cpu_wr(2'd0, 16'h000A);
    cpu_wr(2'd1, 16'd0);
    cpu_wr(2'd0, 16'h000B);
    cpu_wr(2'd0, 16'h000C);
    en = 1'b1;
    wait_pulse(10, n);
    chk("z_lat", n, 2);
    chk("z_dA", snd_data, 16'h000A);
    wait_pulse(10, n);
    chk("z_gap", n, 4);
    chk("z_dB", snd_data, 16'h000B);
    wait_pulse(10, n);
    chk("b2b_gap", n, 2);
    chk("b2b_dC", snd_data, 16'h000C);
    tick();
    chk("b2b_low", snd_wr_en, 1'b0);

    en = 1'b0;
    cpu_wr(2'd0, 16'h0001);
    cpu_wr(2'd0, 16'h0002);
    en = 1'b1;
    cpu_wr(2'd0, 16'h0003);
    chk("pp_level", data_out, 16'h4002);
    en = 1'b0;
    cpu_wr(2'd2, 16'h0001);
    chk("pp_flush", data_out, 16'h0000);

    cpu_wr(2'd0, 16'h0005);
    cpu_wr(2'd1, 16'd5);
    cpu_wr(2'd0, 16'h0006);
    en = 1'b1;
    wait_pulse(10, n);
    chk("rw_lat", n, 2);
    repeat (5) tick();
    chk("rw_busy", data_out, 16'h4001);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rw_dout", data_out, 16'h0000);
    chk("rw_wr", snd_wr_en, 1'b0);
    cnt = 0;
    repeat (30) begin
      tick();
      if (snd_wr_en) cnt++;
    end
    chk("rw_nowr", cnt, 0);

    en = 1'b0;
    cpu_wr(2'd2, 16'h0002);
    for (int i = 0; i < 6; i++) cpu_wr(2'd0, 16'h0100 + 16'(i));
    chk("irq_lvl6", data_out, 16'h4006);
    chk("irq_6", irq, 1'b0);
    en = 1'b1;
    tick();
    chk("irq_lvl5", data_out[4:0], 5'd5);
    chk("irq_5a", irq, 1'b0);
    tick();
    chk("irq_5b", irq, 1'b0);
    tick();
    chk("irq_lvl4", data_out[4:0], 5'd4);
    chk("irq_4", irq, IRQ_ON);
    repeat (30) tick();
    chk("irq_drain", data_out, 16'h0000);
    chk("irq_0", irq, IRQ_ON);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
